// File: rtl/light_sequence_monitor.sv
// rtl/light_sequence_monitor.sv - independent checker of crossroads lamp order and phase durations
// Decodes the six lamps, locks onto the phase sequence and latches the first coded fault.
module light_sequence_monitor #(
    parameter int T_NS_GREEN = 10,
    parameter int T_NS_AMBER = 3,
    parameter int T_ALL_RED  = 1,
    parameter int T_EW_GREEN = 10,
    parameter int T_EW_AMBER = 3,
    parameter int CW         = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic          ns_red,
    input  logic          ns_amber,
    input  logic          ns_green,
    input  logic          ew_red,
    input  logic          ew_amber,
    input  logic          ew_green,
    input  logic          fault_clr,
    output logic          fault,
    output logic [2:0]    fault_code,
    output logic          synced,
    output logic [2:0]    phase,
    output logic [CW-1:0] tick_count
);

    typedef enum logic [1:0] {SYNC, TRACK, FAULT} state_t;

    localparam logic [2:0] PAT_NSG  = 3'd0;
    localparam logic [2:0] PAT_NSA  = 3'd1;
    localparam logic [2:0] PAT_AR   = 3'd2;
    localparam logic [2:0] PAT_EWG  = 3'd3;
    localparam logic [2:0] PAT_EWA  = 3'd4;
    localparam logic [2:0] PAT_NONE = 3'd7;

    localparam logic [2:0] PH_UNKNOWN = 3'd7;

    localparam logic [2:0] C_CONFLICT = 3'd1;
    localparam logic [2:0] C_LAMP     = 3'd2;
    localparam logic [2:0] C_SEQUENCE = 3'd3;
    localparam logic [2:0] C_SHORT    = 3'd4;
    localparam logic [2:0] C_OVERSTAY = 3'd5;

    state_t          state_q;
    logic            fault_q;
    logic [2:0]      code_q;
    logic            synced_q;
    logic [2:0]      phase_q;
    logic [CW-1:0]   cnt_q;
    logic            has_q;
    logic [2:0]      spat_q;

    logic            lamp_err;
    logic            conflict;
    logic [2:0]      lamp_code;
    logic [2:0]      pat;
    logic            sync_ok;
    logic [2:0]      sync_next;
    logic [2:0]      cur_pat;
    logic [2:0]      nxt_phase;
    logic [2:0]      nxt_pat;
    logic [CW-1:0]   t_cur;

    // The AR pattern serves both all-red phases, so phase 5 maps back to it.
    function automatic logic [2:0] phase_pat(input logic [2:0] p);
        return (p == 3'd5) ? PAT_AR : p;
    endfunction

    function automatic logic [CW-1:0] t_of(input logic [2:0] p);
        case (p)
            3'd0:       t_of = CW'(T_NS_GREEN);
            3'd1:       t_of = CW'(T_NS_AMBER);
            3'd2, 3'd5: t_of = CW'(T_ALL_RED);
            3'd3:       t_of = CW'(T_EW_GREEN);
            3'd4:       t_of = CW'(T_EW_AMBER);
            default:    t_of = '0;
        endcase
    endfunction

    always_comb begin
        lamp_err  = !$onehot({ns_red, ns_amber, ns_green}) || !$onehot({ew_red, ew_amber, ew_green});
        conflict  = (ns_amber | ns_green) & (ew_amber | ew_green);
        lamp_code = conflict ? C_CONFLICT : (lamp_err ? C_LAMP : 3'd0);
        pat       = PAT_NONE;
        if (!lamp_err && !conflict) begin
            if (ns_green)      pat = PAT_NSG;
            else if (ns_amber) pat = PAT_NSA;
            else if (ew_green) pat = PAT_EWG;
            else if (ew_amber) pat = PAT_EWA;
            else               pat = PAT_AR;
        end
    end

    always_comb begin
        sync_ok   = 1'b0;
        sync_next = PH_UNKNOWN;
        case (spat_q)
            PAT_NSG: if (pat == PAT_NSA) begin sync_ok = 1'b1; sync_next = 3'd1; end
            PAT_NSA: if (pat == PAT_AR)  begin sync_ok = 1'b1; sync_next = 3'd2; end
            PAT_AR: begin
                if (pat == PAT_NSG) begin sync_ok = 1'b1; sync_next = 3'd0; end
                if (pat == PAT_EWG) begin sync_ok = 1'b1; sync_next = 3'd3; end
            end
            PAT_EWG: if (pat == PAT_EWA) begin sync_ok = 1'b1; sync_next = 3'd4; end
            PAT_EWA: if (pat == PAT_AR)  begin sync_ok = 1'b1; sync_next = 3'd5; end
            default: ;
        endcase
    end

    always_comb begin
        cur_pat   = phase_pat(phase_q);
        nxt_phase = (phase_q == 3'd5) ? 3'd0 : phase_q + 3'd1;
        nxt_pat   = phase_pat(nxt_phase);
        t_cur     = t_of(phase_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= SYNC;
            fault_q  <= 1'b0;
            code_q   <= 3'd0;
            synced_q <= 1'b0;
            phase_q  <= PH_UNKNOWN;
            cnt_q    <= '0;
            has_q    <= 1'b0;
            spat_q   <= PAT_NONE;
        end else begin
            case (state_q)
                SYNC: begin
                    if (lamp_code != 3'd0) begin
                        state_q <= FAULT;
                        fault_q <= 1'b1;
                        code_q  <= lamp_code;
                    end else if (!has_q) begin
                        has_q   <= 1'b1;
                        spat_q  <= pat;
                        phase_q <= (pat == PAT_AR) ? PH_UNKNOWN : pat;
                    end else if (pat != spat_q) begin
                        if (sync_ok) begin
                            state_q  <= TRACK;
                            synced_q <= 1'b1;
                            phase_q  <= sync_next;
                            cnt_q    <= '0;
                        end else begin
                            state_q <= FAULT;
                            fault_q <= 1'b1;
                            code_q  <= C_SEQUENCE;
                        end
                    end
                end
                TRACK: begin
                    if (lamp_code != 3'd0) begin
                        state_q  <= FAULT;
                        fault_q  <= 1'b1;
                        code_q   <= lamp_code;
                        synced_q <= 1'b0;
                    end else if (pat == cur_pat) begin
                        if (tick) begin
                            if (cnt_q == t_cur) begin
                                state_q  <= FAULT;
                                fault_q  <= 1'b1;
                                code_q   <= C_OVERSTAY;
                                synced_q <= 1'b0;
                            end else begin
                                cnt_q <= cnt_q + CW'(1);
                            end
                        end
                    end else if (pat == nxt_pat) begin
                        if (cnt_q == t_cur) begin
                            phase_q <= nxt_phase;
                            cnt_q   <= tick ? CW'(1) : '0;
                        end else begin
                            state_q  <= FAULT;
                            fault_q  <= 1'b1;
                            code_q   <= C_SHORT;
                            synced_q <= 1'b0;
                        end
                    end else begin
                        state_q  <= FAULT;
                        fault_q  <= 1'b1;
                        code_q   <= C_SEQUENCE;
                        synced_q <= 1'b0;
                    end
                end
                FAULT: begin
                    synced_q <= 1'b0;
                    if (fault_clr) begin
                        state_q <= SYNC;
                        fault_q <= 1'b0;
                        code_q  <= 3'd0;
                        phase_q <= PH_UNKNOWN;
                        cnt_q   <= '0;
                        has_q   <= 1'b0;
                        spat_q  <= PAT_NONE;
                    end
                end
                default: state_q <= SYNC;
            endcase
        end
    end

    assign fault      = fault_q;
    assign fault_code = code_q;
    assign synced     = synced_q;
    assign phase      = phase_q;
    assign tick_count = cnt_q;

endmodule

// File: tb/tb_light_sequence_monitor.sv
// tb/tb_light_sequence_monitor.sv - scoreboard bench for light_sequence_monitor
// Expected output words are queued with each driven cycle and compared against sampled outputs.
module tb_light_sequence_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic [5:0] lamps = 6'b0;
    logic       fault_clr = 1'b0;
    logic       fault;
    logic [2:0] fault_code;
    logic       synced;
    logic [2:0] phase;
    logic [7:0] tick_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_q[$];
    logic [15:0] obs_q[$];
    int          T[6] = '{4, 2, 1, 4, 2, 1};

    localparam logic [5:0] L_NSG = 6'b001_100;
    localparam logic [5:0] L_NSA = 6'b010_100;
    localparam logic [5:0] L_AR  = 6'b100_100;
    localparam logic [5:0] L_EWG = 6'b100_001;
    localparam logic [5:0] L_EWA = 6'b100_010;

    light_sequence_monitor #(
        .T_NS_GREEN(4), .T_NS_AMBER(2), .T_ALL_RED(1),
        .T_EW_GREEN(4), .T_EW_AMBER(2), .CW(8)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick),
        .ns_red(lamps[5]), .ns_amber(lamps[4]), .ns_green(lamps[3]),
        .ew_red(lamps[2]), .ew_amber(lamps[1]), .ew_green(lamps[0]),
        .fault_clr(fault_clr), .fault(fault), .fault_code(fault_code),
        .synced(synced), .phase(phase), .tick_count(tick_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [15:0] mk(input int f, input int c, input int s, input int p, input int n);
        return {f[0], c[2:0], s[0], p[2:0], n[7:0]};
    endfunction

    function automatic logic [5:0] lamp_of(input int p);
        case (p)
            0: return L_NSG;
            1: return L_NSA;
            3: return L_EWG;
            4: return L_EWA;
            default: return L_AR;
        endcase
    endfunction

    function automatic logic [15:0] observed();
        return {fault, fault_code, synced, phase, tick_count};
    endfunction

    task automatic cyc(input logic [5:0] l, input logic t, input logic clr, input logic [15:0] e);
        lamps = l; tick = t; fault_clr = clr;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        obs_q.push_back(observed());
        tick = 1'b0; fault_clr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; lamps = 6'b0; tick = 1'b0; fault_clr = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic enter(input int p, input bit t);
        cyc(lamp_of(p), t, 1'b0, mk(0, 0, 1, p, t ? 1 : 0));
    endtask

    task automatic tick_n(input int p, input int c0, input int n);
        for (int k = 1; k <= n; k++) cyc(lamp_of(p), 1'b1, 1'b0, mk(0, 0, 1, p, c0 + k));
    endtask

    task automatic start_track();
        do_reset();
        cyc(L_NSG, 1'b0, 1'b0, mk(0, 0, 0, 0, 0));
        cyc(L_NSA, 1'b0, 1'b0, mk(0, 0, 1, 1, 0));
    endtask

    task automatic finish_round_from_ns_a();
        tick_n(1, 0, 2);
        for (int p = 2; p <= 5; p++) begin
            enter(p, 1'b0);
            tick_n(p, 0, T[p]);
        end
    endtask

    task automatic test_reset();
        logic [15:0] o;
        rst = 1'b1;
        @(posedge clk);
        #1;
        o = observed();
        n_checks++;
        if (o !== mk(0, 0, 0, 7, 0)) begin
            n_fail++;
            $display("FAIL reset: got %h want %h", o, mk(0, 0, 0, 7, 0));
        end
    endtask

    task automatic test_legal();
        logic [15:0] e, o;
        int idx = 0;
        start_track();
        finish_round_from_ns_a();
        for (int r = 0; r < 3; r++)
            for (int p = 0; p <= 5; p++) begin
                enter(p, 1'b0);
                tick_n(p, 0, T[p]);
            end
        enter(0, 1'b1);
        tick_n(0, 1, 3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL legal step %0d: got f%0b c%0d s%0b p%0d n%0d want f%0b c%0d s%0b p%0d n%0d",
                         idx, o[15], o[14:12], o[11], o[10:8], o[7:0], e[15], e[14:12], e[11], e[10:8], e[7:0]);
            end
            idx++;
        end
    endtask

    task automatic test_conflict();
        logic [15:0] e, o;
        int idx = 0;
        start_track();
        tick_n(1, 0, 1);
        cyc(6'b001_001, 1'b0, 1'b1, mk(1, 1, 0, 1, 1));
        for (int k = 0; k < 4; k++) cyc(L_NSA, 1'b1, 1'b0, mk(1, 1, 0, 1, 1));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL conflict step %0d: got f%0b c%0d s%0b p%0d n%0d want f%0b c%0d s%0b p%0d n%0d",
                         idx, o[15], o[14:12], o[11], o[10:8], o[7:0], e[15], e[14:12], e[11], e[10:8], e[7:0]);
            end
            idx++;
        end
    endtask

    task automatic test_short();
        logic [15:0] e, o;
        int idx = 0;
        start_track();
        finish_round_from_ns_a();
        enter(0, 1'b0);
        tick_n(0, 0, 3);
        cyc(L_NSA, 1'b0, 1'b0, mk(1, 4, 0, 0, 3));
        cyc(L_NSA, 1'b0, 1'b1, mk(0, 0, 0, 7, 0));
        cyc(L_NSA, 1'b0, 1'b0, mk(0, 0, 0, 1, 0));
        enter(2, 1'b0);
        tick_n(2, 0, 1);
        enter(3, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL short step %0d: got f%0b c%0d s%0b p%0d n%0d want f%0b c%0d s%0b p%0d n%0d",
                         idx, o[15], o[14:12], o[11], o[10:8], o[7:0], e[15], e[14:12], e[11], e[10:8], e[7:0]);
            end
            idx++;
        end
    endtask

    task automatic test_overstay();
        logic [15:0] e, o;
        int idx = 0;
        start_track();
        tick_n(1, 0, 2);
        enter(2, 1'b0);
        tick_n(2, 0, 1);
        enter(3, 1'b0);
        tick_n(3, 0, 4);
        cyc(L_EWG, 1'b1, 1'b0, mk(1, 5, 0, 3, 4));
        cyc(L_EWG, 1'b1, 1'b0, mk(1, 5, 0, 3, 4));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL overstay step %0d: got f%0b c%0d s%0b p%0d n%0d want f%0b c%0d s%0b p%0d n%0d",
                         idx, o[15], o[14:12], o[11], o[10:8], o[7:0], e[15], e[14:12], e[11], e[10:8], e[7:0]);
            end
            idx++;
        end
    endtask

    task automatic test_seq_lamp();
        logic [15:0] e, o;
        int idx = 0;
        start_track();
        finish_round_from_ns_a();
        enter(0, 1'b0);
        tick_n(0, 0, 4);
        cyc(L_EWA, 1'b0, 1'b0, mk(1, 3, 0, 0, 4));
        cyc(L_EWA, 1'b0, 1'b1, mk(0, 0, 0, 7, 0));
        cyc(6'b101_100, 1'b0, 1'b0, mk(1, 2, 0, 7, 0));
        cyc(L_NSG, 1'b0, 1'b1, mk(0, 0, 0, 7, 0));
        cyc(6'b011_001, 1'b0, 1'b0, mk(1, 1, 0, 7, 0));
        cyc(L_NSG, 1'b0, 1'b1, mk(0, 0, 0, 7, 0));
        cyc(L_NSG, 1'b0, 1'b0, mk(0, 0, 0, 0, 0));
        cyc(L_EWG, 1'b0, 1'b0, mk(1, 3, 0, 0, 0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL seq_lamp step %0d: got f%0b c%0d s%0b p%0d n%0d want f%0b c%0d s%0b p%0d n%0d",
                         idx, o[15], o[14:12], o[11], o[10:8], o[7:0], e[15], e[14:12], e[11], e[10:8], e[7:0]);
            end
            idx++;
        end
    endtask

    task automatic test_async_reset();
        logic [15:0] e, o;
        int idx = 0;
        start_track();
        tick_n(1, 0, 2);
        enter(2, 1'b0);
        tick_n(2, 0, 1);
        enter(3, 1'b0);
        tick_n(3, 0, 4);
        enter(4, 1'b0);
        tick_n(4, 0, 1);
        #2;
        rst = 1'b1;
        #1;
        o = observed();
        n_checks++;
        if (o !== mk(0, 0, 0, 7, 0)) begin
            n_fail++;
            $display("FAIL async_reset immediate: got %h want %h", o, mk(0, 0, 0, 7, 0));
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(L_EWA, 1'b0, 1'b0, mk(0, 0, 0, 4, 0));
        cyc(L_AR, 1'b0, 1'b0, mk(0, 0, 1, 5, 0));
        tick_n(5, 0, 1);
        enter(0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL async_reset step %0d: got f%0b c%0d s%0b p%0d n%0d want f%0b c%0d s%0b p%0d n%0d",
                         idx, o[15], o[14:12], o[11], o[10:8], o[7:0], e[15], e[14:12], e[11], e[10:8], e[7:0]);
            end
            idx++;
        end
    endtask

    initial begin
        test_reset();
        test_legal();
        test_conflict();
        test_short();
        test_overstay();
        test_seq_lamp();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
